tlc_phase_scheduler: RTL

Demand-actuated phase scheduler for the six-approach intersection (M1, M2, M3, M4, R, S).
- Sequences five phases in round-robin order, visiting only phases with pending demand.
- Enforces minimum and maximum green, fixed yellow and an all-red clearance interval.
- Drives the 2-bit light codes (10 green, 01 yellow, 00 red) consumed by the signal head drivers. This replaces the fixed-time cycle.

---
 rtl/tlc_pkg.sv | 55 +++++
 rtl/tlc_tick_gen.sv | 28 ++
 rtl/tlc_phase_scheduler.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/tlc_pkg.sv
// Shared types and constants for the demand-actuated phase scheduler:
// light codes, controller states, phase indices and the phase-to-signal green mask.
package tlc_pkg;

  localparam logic [1:0] LT_GREEN  = 2'b10;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b00;

  typedef enum logic [1:0] {
    ST_GREEN  = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_t;

  localparam int NUM_PHASES  = 5;
  localparam int NUM_SIGNALS = 6;

  localparam logic [2:0] PH_MAIN = 3'd0;
  localparam logic [2:0] PH_M13  = 3'd1;
  localparam logic [2:0] PH_M24  = 3'd2;
  localparam logic [2:0] PH_R    = 3'd3;
  localparam logic [2:0] PH_S    = 3'd4;

  // Signal bit order: 0=M1 1=M2 2=M3 3=M4 4=R 5=S; element p is phase Pp.
  localparam logic [NUM_PHASES-1:0][NUM_SIGNALS-1:0] PHASE_MASK = {
    6'b100000, 6'b010000, 6'b001010, 6'b000101, 6'b000011
  };

  function automatic logic [NUM_SIGNALS-1:0] green_mask(input logic [2:0] ph);
    case (ph)
      PH_MAIN: return PHASE_MASK[0];
      PH_M13:  return PHASE_MASK[1];
      PH_M24:  return PHASE_MASK[2];
      PH_R:    return PHASE_MASK[3];
      PH_S:    return PHASE_MASK[4];
      default: return 6'b000000;
    endcase
  endfunction

  function automatic logic [2:0] phase_step(input logic [2:0] ph, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, ph} + {1'b0, k};
    if (s >= 4'd5) begin
      s = s - 4'd5;
    end else begin
      s = s;
    end
    return s[2:0];
  endfunction

  function automatic logic [NUM_PHASES-1:0] phase_onehot(input logic [2:0] ph);
    return 5'b00001 << ph;
  endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Timing-tick prescaler: tick is high for one clk out of every TICK_DIV.
module tlc_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_r;

  // Prescaler counting 0..TICK_DIV-1 and wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_r <= '0;
    end else if (presc_r == LAST) begin
      presc_r <= '0;
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  assign tick = (presc_r == LAST);

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-actuated five-phase scheduler with min/max green, yellow and all-red clearance.
// Optional preemption to the main phase is enabled by defining TLC_PREEMPT_EN.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int TICK_DIV  = 1,
  parameter int GREEN_MIN = 3,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] req,
`ifdef TLC_PREEMPT_EN
  input  logic       preempt,
`endif
  output logic [1:0] light_M1,
  output logic [1:0] light_M2,
  output logic [1:0] light_M3,
  output logic [1:0] light_M4,
  output logic [1:0] light_R,
  output logic [1:0] light_S,
  output logic [2:0] phase,
  output logic [1:0] state,
  output logic [3:0] count
);

  localparam logic [4:0] G_MIN = 5'(GREEN_MIN);
  localparam logic [4:0] G_MAX = 5'(GREEN_MAX);
  localparam logic [4:0] Y_T   = 5'(YELLOW_T);
  localparam logic [4:0] AR_T  = 5'(ALLRED_T);
  localparam logic [NUM_SIGNALS-1:0][1:0] RESET_LIGHTS =
    {LT_RED, LT_RED, LT_RED, LT_RED, LT_GREEN, LT_GREEN};

  state_t                        state_r, state_nx;
  logic [2:0]                    phase_r, phase_nx, nxt_r, nxt_nx, nxt_eff, sel;
  logic [3:0]                    count_r;
  logic [4:0]                    elapsed;
  logic [4:0]                    pending_r, pending_nx, eff_pending, enter_green, green_self;
  logic                          tick, other_pending, sel_found;
  logic                          preempt_go, preempt_hold, preempt_ovr;
  logic [NUM_SIGNALS-1:0][1:0]   lights_r, lights_nx;
  logic [NUM_SIGNALS-1:0]        cur_mask, nxt_mask;

  tlc_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

`ifdef TLC_PREEMPT_EN
  assign preempt_go   = preempt && (state_r == ST_GREEN) && (phase_r != PH_MAIN);
  assign preempt_hold = preempt && (phase_r == PH_MAIN);
  assign preempt_ovr  = preempt;
`else
  assign preempt_go   = 1'b0;
  assign preempt_hold = 1'b0;
  assign preempt_ovr  = 1'b0;
`endif

  assign elapsed       = {1'b0, count_r} + 5'd1;
  // The main phase is always recalled while another phase is being served.
  assign eff_pending   = pending_r | ((phase_r != PH_MAIN) ? 5'b00001 : 5'b00000);
  assign other_pending = |(eff_pending & ~phase_onehot(phase_r));
  assign green_self    = (state_r == ST_GREEN) ? phase_onehot(phase_r) : 5'b00000;
  assign nxt_eff       = preempt_ovr ? PH_MAIN : nxt_r;

  // Round-robin search for the first pending phase after the current one.
  always_comb begin
    sel       = phase_r;
    sel_found = 1'b0;
    for (int k = 1; k < NUM_PHASES; k++) begin
      if (!sel_found && eff_pending[phase_step(phase_r, 3'(k))]) begin
        sel       = phase_step(phase_r, 3'(k));
        sel_found = 1'b1;
      end else begin
        sel_found = sel_found;
      end
    end
  end

  // Next-state logic for the green/yellow/all-red sequencer.
  always_comb begin
    state_nx    = state_r;
    phase_nx    = phase_r;
    nxt_nx      = nxt_r;
    enter_green = 5'b00000;
    case (state_r)
      ST_GREEN: begin
        if (preempt_go) begin
          state_nx = ST_YELLOW;
          nxt_nx   = PH_MAIN;
        end else if (tick && !preempt_hold && (elapsed >= G_MIN) && other_pending &&
                     (!req[phase_r] || (elapsed >= G_MAX))) begin
          state_nx = ST_YELLOW;
          nxt_nx   = sel;
        end else begin
          state_nx = ST_GREEN;
        end
      end
      ST_YELLOW: begin
        nxt_nx = nxt_eff;
        if (tick && (elapsed == Y_T)) begin
          state_nx = ST_ALLRED;
        end else begin
          state_nx = ST_YELLOW;
        end
      end
      ST_ALLRED: begin
        nxt_nx = nxt_eff;
        if (tick && (elapsed == AR_T)) begin
          state_nx    = ST_GREEN;
          phase_nx    = nxt_eff;
          enter_green = phase_onehot(nxt_eff);
        end else begin
          state_nx = ST_ALLRED;
        end
      end
      default: begin
        state_nx = ST_GREEN;
        phase_nx = PH_MAIN;
        nxt_nx   = PH_MAIN;
      end
    endcase
    pending_nx = (pending_r | (req & ~green_self)) & ~enter_green;
  end

  // Light decode from the next state so lamps change in the same cycle as state.
  always_comb begin
    lights_nx = 12'h000;
    cur_mask  = green_mask(phase_nx);
    nxt_mask  = green_mask(nxt_nx);
    for (int s = 0; s < NUM_SIGNALS; s++) begin
      case (state_nx)
        ST_GREEN:  lights_nx[s] = cur_mask[s] ? LT_GREEN : LT_RED;
        ST_YELLOW: lights_nx[s] = (cur_mask[s] && nxt_mask[s]) ? LT_GREEN :
                                  (cur_mask[s] ? LT_YELLOW : LT_RED);
        ST_ALLRED: lights_nx[s] = (cur_mask[s] && nxt_mask[s]) ? LT_GREEN : LT_RED;
        default:   lights_nx[s] = LT_RED;
      endcase
    end
  end

  // Sequencer, demand latch, tick counter and light registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_GREEN;
      phase_r   <= PH_MAIN;
      nxt_r     <= PH_MAIN;
      count_r   <= 4'd0;
      pending_r <= 5'b00000;
      lights_r  <= RESET_LIGHTS;
    end else begin
      state_r   <= state_nx;
      phase_r   <= phase_nx;
      nxt_r     <= nxt_nx;
      pending_r <= pending_nx;
      lights_r  <= lights_nx;
      if (state_nx != state_r) begin
        count_r <= 4'd0;
      end else if (tick && (count_r != 4'd15)) begin
        count_r <= count_r + 4'd1;
      end else begin
        count_r <= count_r;
      end
    end
  end

  assign phase    = phase_r;
  assign state    = state_r;
  assign count    = count_r;
  assign light_M1 = lights_r[0];
  assign light_M2 = lights_r[1];
  assign light_M3 = lights_r[2];
  assign light_M4 = lights_r[3];
  assign light_R  = lights_r[4];
  assign light_S  = lights_r[5];

endmodule
